// File: rtl/s_mem_phase_sched_if.sv
// Phase-engine / s_memory bus bundle for the RC4 phase scheduler.
// master = scheduler side, slave = phase engines plus memory.
interface s_mem_phase_sched_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [2:0]          ph_start;
    logic [2:0]          ph_done;
    logic [2:0]          ph_req;
    logic [2:0]          ph_wren;
    logic [3*ADDR_W-1:0] ph_addr;
    logic [3*DATA_W-1:0] ph_wdata;
    logic [2:0]          ph_gnt;
    logic [2:0]          ph_rvalid;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_wren;

    modport master (
        input  ph_done, ph_req, ph_wren, ph_addr, ph_wdata,
        output ph_start, ph_gnt, ph_rvalid,
        output mem_addr, mem_data, mem_wren
    );

    modport slave (
        output ph_done, ph_req, ph_wren, ph_addr, ph_wdata,
        input  ph_start, ph_gnt, ph_rvalid,
        input  mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/s_mem_phase_sched.sv
// RC4 phase sequencer: runs INIT, KSA, PRGA in turn and hands the single
// s_memory port to whichever phase is active, tracking its read returns.
module s_mem_phase_sched #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    s_mem_phase_sched_if.master  bus,
    output logic [1:0]           phase,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN0, S_RUN1, S_RUN2, S_DONE, S_ERR
    } state_t;

    localparam bit          WD_EN    = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam int          PIDW     = 2 * RD_LAT;

    state_t            state_q, state_d;
    logic [15:0]       timer_q;
    logic [2:0]        run;
    logic [2:0]        enter;
    logic [2:0]        gnt;
    logic [1:0]        gnt_id;
    logic              tmo;
    logic              rd_push;
    logic [RD_LAT-1:0] pv_q;
    logic [PIDW-1:0]   pid_q;
    logic [1:0]        pid_last;

    always_comb begin
        run   = {state_q == S_RUN2, state_q == S_RUN1, state_q == S_RUN0};
        tmo   = WD_EN && (|run) && (timer_q == TMO_LAST);
        gnt   = run & bus.ph_req;
        enter = {state_d == S_RUN2 && state_q != S_RUN2,
                 state_d == S_RUN1 && state_q != S_RUN1,
                 state_d == S_RUN0 && state_q != S_RUN0};
    end

    // abort outranks everything, timeout outranks a same-cycle done
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RUN0: if (tmo) state_d = S_ERR;
                        else if (bus.ph_done[0]) state_d = S_RUN1;
                S_RUN1: if (tmo) state_d = S_ERR;
                        else if (bus.ph_done[1]) state_d = S_RUN2;
                S_RUN2: if (tmo) state_d = S_ERR;
                        else if (bus.ph_done[2]) state_d = S_DONE;
                default: if (start) state_d = S_RUN0;
            endcase
        end
    end

    always_comb begin
        bus.mem_addr = '0;
        bus.mem_data = '0;
        bus.mem_wren = 1'b0;
        gnt_id       = 2'd0;
        unique case (1'b1)
            gnt[0]: begin
                bus.mem_addr = bus.ph_addr[0 +: ADDR_W];
                bus.mem_data = bus.ph_wdata[0 +: DATA_W];
                bus.mem_wren = bus.ph_wren[0];
                gnt_id       = 2'd0;
            end
            gnt[1]: begin
                bus.mem_addr = bus.ph_addr[ADDR_W +: ADDR_W];
                bus.mem_data = bus.ph_wdata[DATA_W +: DATA_W];
                bus.mem_wren = bus.ph_wren[1];
                gnt_id       = 2'd1;
            end
            gnt[2]: begin
                bus.mem_addr = bus.ph_addr[2*ADDR_W +: ADDR_W];
                bus.mem_data = bus.ph_wdata[2*DATA_W +: DATA_W];
                bus.mem_wren = bus.ph_wren[2];
                gnt_id       = 2'd2;
            end
            default: ;
        endcase
    end

    assign bus.ph_gnt = gnt;
    assign rd_push    = (|(gnt & ~bus.ph_wren)) & ~abort;
    assign pid_last   = pid_q[PIDW-1 -: 2];
    assign bus.ph_rvalid = pv_q[RD_LAT-1] ? (3'b001 << pid_last) : 3'b000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bus.ph_start <= '0;
            phase        <= 2'd3;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus.ph_start <= enter;
            busy         <= state_d inside {S_RUN0, S_RUN1, S_RUN2};
            done         <= state_d == S_DONE;
            err          <= state_d == S_ERR;
            case (state_d)
                S_RUN0:  phase <= 2'd0;
                S_RUN1:  phase <= 2'd1;
                S_RUN2:  phase <= 2'd2;
                default: phase <= 2'd3;
            endcase
            if (state_d != state_q)
                timer_q <= '0;
            else if ((|run) && timer_q != 16'hFFFF)
                timer_q <= timer_q + 16'd1;
        end
    end

    // read-return pipe keeps its phase tag so late returns still land
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv_q  <= '0;
            pid_q <= '0;
        end else if (abort) begin
            pv_q  <= '0;
            pid_q <= '0;
        end else begin
            pv_q  <= (pv_q << 1) | RD_LAT'(rd_push);
            pid_q <= (pid_q << 2) | PIDW'(gnt_id);
        end
    end
endmodule

// File: tb/tb_s_mem_phase_sched.sv
// Scoreboard bench: directed phase sequences on two scheduler instances
// (fast-return full RC4 run, and a short-watchdog two-cycle-latency unit).
module tb_s_mem_phase_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_a, start_a, abort_a, busy_a, done_a, err_a;
    logic rst_b, start_b, abort_b, busy_b, done_b, err_b;
    logic [1:0] phase_a, phase_b;

    s_mem_phase_sched_if #(.ADDR_W(8), .DATA_W(8)) ma ();
    s_mem_phase_sched_if #(.ADDR_W(8), .DATA_W(8)) mb ();

    s_mem_phase_sched #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .TIMEOUT(4096)) u_a (
        .clk(clk), .reset_n(rst_a), .start(start_a), .abort(abort_a),
        .bus(ma), .phase(phase_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    s_mem_phase_sched #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .TIMEOUT(16)) u_b (
        .clk(clk), .reset_n(rst_b), .start(start_b), .abort(abort_b),
        .bus(mb), .phase(phase_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // s_memory model behind instance a (registered read, 1-cycle latency)
    logic [7:0] smem [256];
    logic [7:0] mq;
    always @(posedge clk) begin
        if (ma.mem_wren) smem[ma.mem_addr] <= ma.mem_data;
        mq <= smem[ma.mem_addr];
    end

    int qa_mask[$], qa_due[$];
    int qb_mask[$], qb_due[$];

    always @(negedge clk) begin
        if (qa_due.size() > 0 && qa_due[0] < cyc) begin
            checks++; errors++;
            $display("FAIL rvalid_a_missing got none required mask %0d at cyc %0d",
                     qa_mask[0], qa_due[0]);
            void'(qa_mask.pop_front()); void'(qa_due.pop_front());
        end
        if (ma.ph_rvalid != 3'b000) begin
            checks++;
            if (qa_mask.size() == 0) begin
                errors++;
                $display("FAIL rvalid_a_unexpected got %b at cyc %0d required none",
                         ma.ph_rvalid, cyc);
            end else begin
                if (ma.ph_rvalid != qa_mask[0][2:0] || cyc != qa_due[0]) begin
                    errors++;
                    $display("FAIL rvalid_a got %b@%0d required %b@%0d",
                             ma.ph_rvalid, cyc, qa_mask[0][2:0], qa_due[0]);
                end
                void'(qa_mask.pop_front()); void'(qa_due.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (qb_due.size() > 0 && qb_due[0] < cyc) begin
            checks++; errors++;
            $display("FAIL rvalid_b_missing got none required mask %0d at cyc %0d",
                     qb_mask[0], qb_due[0]);
            void'(qb_mask.pop_front()); void'(qb_due.pop_front());
        end
        if (mb.ph_rvalid != 3'b000) begin
            checks++;
            if (qb_mask.size() == 0) begin
                errors++;
                $display("FAIL rvalid_b_unexpected got %b at cyc %0d required none",
                         mb.ph_rvalid, cyc);
            end else begin
                if (mb.ph_rvalid != qb_mask[0][2:0] || cyc != qb_due[0]) begin
                    errors++;
                    $display("FAIL rvalid_b got %b@%0d required %b@%0d",
                             mb.ph_rvalid, cyc, qb_mask[0][2:0], qb_due[0]);
                end
                void'(qb_mask.pop_front()); void'(qb_due.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_rd(input int p, input logic [7:0] addr, output logic [7:0] d);
        ma.ph_req[p]          = 1'b1;
        ma.ph_wren[p]         = 1'b0;
        ma.ph_addr[p*8 +: 8]  = addr;
        qa_mask.push_back(1 << p);
        qa_due.push_back(cyc + 1);
        tick();
        ma.ph_req[p] = 1'b0;
        d = mq;
    endtask

    task automatic a_wr(input int p, input logic [7:0] addr, input logic [7:0] d);
        ma.ph_req[p]          = 1'b1;
        ma.ph_wren[p]         = 1'b1;
        ma.ph_addr[p*8 +: 8]  = addr;
        ma.ph_wdata[p*8 +: 8] = d;
        tick();
        ma.ph_req[p]  = 1'b0;
        ma.ph_wren[p] = 1'b0;
    endtask

    task automatic a_done(input int p);
        ma.ph_done[p] = 1'b1;
        tick();
        ma.ph_done[p] = 1'b0;
    endtask

    task automatic a_wait_start(input int p);
        int n;
        n = 0;
        while (!ma.ph_start[p] && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("ph_start_a%0d_seen", p), 32'(ma.ph_start[p]), 32'd1);
    endtask

    logic [7:0] gs [256];
    logic [7:0] key [3];

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "bench watchdog");
    end

    initial begin
        logic [7:0] si, sj, j, t;
        logic [2:0] seen;
        int mism, cnt;

        key = '{8'h00, 8'h02, 8'h49};
        for (int i = 0; i < 256; i++) gs[i] = 8'(i);
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + gs[i] + key[i % 3];
            t = gs[i]; gs[i] = gs[j]; gs[j] = t;
        end
        j = 8'd0;
        for (int k = 1; k <= 32; k++) begin
            j = j + gs[k];
            t = gs[k]; gs[k] = gs[j]; gs[j] = t;
        end

        rst_a = 0; start_a = 0; abort_a = 0;
        rst_b = 0; start_b = 0; abort_b = 0;
        ma.ph_done = '0; ma.ph_req = '0; ma.ph_wren = '0;
        ma.ph_addr = '0; ma.ph_wdata = '0;
        mb.ph_done = '0; mb.ph_req = '0; mb.ph_wren = '0;
        mb.ph_addr = '0; mb.ph_wdata = '0;
        tick(); tick();

        chk("reset_phase", 32'(phase_a), 32'd3);
        chk("reset_flags", {29'd0, busy_a, done_a, err_a}, 32'd0);
        chk("reset_ph_start", 32'(ma.ph_start), 32'd0);
        rst_a = 1; rst_b = 1;
        tick();

        // T1: async reset in the middle of RUN1
        start_a = 1; tick(); start_a = 0;
        chk("t1_start0", 32'(ma.ph_start), 32'b001);
        chk("t1_phase0", 32'(phase_a), 32'd0);
        a_done(0);
        chk("t1_phase1", 32'(phase_a), 32'd1);
        ma.ph_req[1] = 1'b1; ma.ph_wren[1] = 1'b1; ma.ph_addr[15:8] = 8'd7;
        #1;
        chk("t1_gnt_before", 32'(ma.ph_gnt), 32'b010);
        #1 rst_a = 0;
        #1;
        chk("t1_rst_gnt", 32'(ma.ph_gnt), 32'd0);
        chk("t1_rst_wren", 32'(ma.mem_wren), 32'd0);
        chk("t1_rst_addr", 32'(ma.mem_addr), 32'd0);
        chk("t1_rst_phase", 32'(phase_a), 32'd3);
        chk("t1_rst_busy", 32'(busy_a), 32'd0);
        ma.ph_req = '0; ma.ph_wren = '0;
        tick();
        rst_a = 1;
        tick();
        start_a = 1; tick(); start_a = 0;
        chk("t1_restart", 32'(ma.ph_start), 32'b001);

        // T3: only the active phase gets the port
        a_done(0);
        chk("t3_start1", 32'(ma.ph_start), 32'b010);
        ma.ph_req = 3'b111; ma.ph_wren = 3'b000;
        ma.ph_addr = {8'd30, 8'd20, 8'd10};
        ma.ph_done = 3'b100;
        #1;
        chk("t3_gnt", 32'(ma.ph_gnt), 32'b010);
        chk("t3_addr", 32'(ma.mem_addr), 32'd20);
        qa_mask.push_back(3'b010);
        qa_due.push_back(cyc + 1);
        tick();
        ma.ph_req = '0; ma.ph_done = '0;
        chk("t3_done2_ignored", 32'(phase_a), 32'd1);
        tick();
        abort_a = 1; tick(); abort_a = 0;
        chk("t3_abort_idle", 32'(phase_a), 32'd3);

        // T2: full INIT/KSA/PRGA run through the scheduler
        start_a = 1; tick(); start_a = 0;
        a_wait_start(0);
        for (int i = 0; i < 256; i++) a_wr(0, 8'(i), 8'(i));
        chk("t2_init_s77", 32'(smem[77]), 32'd77);
        a_done(0);
        a_wait_start(1);
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            a_rd(1, 8'(i), si);
            j = j + si + key[i % 3];
            a_rd(1, j, sj);
            a_wr(1, 8'(i), sj);
            a_wr(1, j, si);
        end
        a_done(1);
        a_wait_start(2);
        j = 8'd0;
        for (int k = 1; k <= 32; k++) begin
            a_rd(2, 8'(k), si);
            j = j + si;
            a_rd(2, j, sj);
            a_wr(2, 8'(k), sj);
            a_wr(2, j, si);
        end
        a_done(2);
        chk("t2_done", 32'(done_a), 32'd1);
        chk("t2_busy", 32'(busy_a), 32'd0);
        chk("t2_phase", 32'(phase_a), 32'd3);
        mism = 0;
        for (int i = 0; i < 256; i++) if (smem[i] !== gs[i]) mism++;
        chk("t2_smem_mismatches", 32'(mism), 32'd0);
        chk("t2_s0", 32'(smem[0]), 32'(gs[0]));
        chk("t2_s255", 32'(smem[255]), 32'(gs[255]));

        // T4: read plus done in the same cycle, return lands in RUN1
        start_b = 1; tick(); start_b = 0;
        chk("t4_start0", 32'(mb.ph_start), 32'b001);
        mb.ph_req[0] = 1'b1; mb.ph_wren[0] = 1'b0; mb.ph_addr[7:0] = 8'd5;
        mb.ph_done[0] = 1'b1;
        #1;
        chk("t4_gnt", 32'(mb.ph_gnt), 32'b001);
        chk("t4_addr", 32'(mb.mem_addr), 32'd5);
        qb_mask.push_back(3'b001);
        qb_due.push_back(cyc + 2);
        tick();
        mb.ph_req = '0; mb.ph_done = '0;
        chk("t4_phase1", 32'(phase_b), 32'd1);
        chk("t4_start1", 32'(mb.ph_start), 32'b010);

        // T5: watchdog fires after 16 cycles in RUN1
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (err_b) break;
            if (busy_b && phase_b == 2'd1) cnt++;
            tick();
        end
        chk("t5_cycles", 32'(cnt), 32'd16);
        chk("t5_err", 32'(err_b), 32'd1);
        start_b = 1; tick(); start_b = 0;
        chk("t5_restart", 32'(mb.ph_start), 32'b001);
        chk("t5_err_clr", 32'(err_b), 32'd0);

        // T6: abort beats done; pending read return is dropped
        mb.ph_req[0] = 1'b1; mb.ph_wren[0] = 1'b0; mb.ph_addr[7:0] = 8'd5;
        mb.ph_done[0] = 1'b1; abort_b = 1;
        tick();
        mb.ph_req = '0; mb.ph_done = '0; abort_b = 0;
        chk("t6_phase", 32'(phase_b), 32'd3);
        chk("t6_busy", 32'(busy_b), 32'd0);
        seen = mb.ph_start;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | mb.ph_start;
        end
        chk("t6_no_start", 32'(seen), 32'd0);

        tick();
        chk("sb_a_empty", 32'(qa_mask.size()), 32'd0);
        chk("sb_b_empty", 32'(qb_mask.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
